// File: rtl/tdm_lut_conf_sequencer.sv
// TDM LUT configuration sequencer.
// Accepts write / clear / commit requests and turns them into registered
// lut_conf_valid / link_en_valid pulses, each followed by CONF_GAP idle cycles.
// Optional shadow readback table is built when TDM_LUT_CONF_SHADOW_EN is defined.
module tdm_lut_conf_sequencer #(
  parameter int TDM_LUT_SIZE = 4,
  parameter int TDM_CHANNELS = 4,
  parameter int CONF_GAP     = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [1:0]                        req_op,
  input  logic [$clog2(TDM_CHANNELS)-1:0]   req_sel,
  input  logic [$clog2(TDM_LUT_SIZE)-1:0]   req_slot,
  input  logic [$clog2(TDM_CHANNELS+1)-1:0] req_data,
  output logic [$clog2(TDM_CHANNELS+1)-1:0] lut_conf_data,
  output logic [$clog2(TDM_CHANNELS)-1:0]   lut_conf_sel,
  output logic [$clog2(TDM_LUT_SIZE)-1:0]   lut_conf_slot,
  output logic                              lut_conf_valid,
  output logic                              link_en_valid,
`ifdef TDM_LUT_CONF_SHADOW_EN
  input  logic [$clog2(TDM_CHANNELS)-1:0]   rd_sel,
  input  logic [$clog2(TDM_LUT_SIZE)-1:0]   rd_slot,
  output logic [$clog2(TDM_CHANNELS+1)-1:0] rd_data,
  output logic [$clog2(TDM_CHANNELS+1)-1:0] link_en_mask,
`endif
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int SEL_W  = $clog2(TDM_CHANNELS);
  localparam int SLOT_W = $clog2(TDM_LUT_SIZE);
  localparam int DATA_W = $clog2(TDM_CHANNELS + 1);

  localparam logic [DATA_W-1:0] UNASSIGNED = DATA_W'(TDM_CHANNELS);
  localparam logic [SEL_W-1:0]  SEL_LAST   = SEL_W'(TDM_CHANNELS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(TDM_LUT_SIZE - 1);
  localparam logic              GAP_EN     = (CONF_GAP > 0);
  localparam logic [3:0]        GAP_LAST   = 4'(CONF_GAP > 0 ? CONF_GAP - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StClear,
    StCommit,
    StGap
  } state_t;

  state_t              r_state, w_state_next;
  logic [SEL_W-1:0]    r_clr_sel, w_clr_sel_next;
  logic [SLOT_W-1:0]   r_clr_slot, w_clr_slot_next;
  logic                r_clearing, w_clearing_next;
  logic [3:0]          r_gap_cnt, w_gap_cnt_next;
  logic                r_init_done;

  logic                r_conf_valid, w_conf_valid_next;
  logic                r_link_valid, w_link_valid_next;
  logic [DATA_W-1:0]   r_data, w_data_next;
  logic [SEL_W-1:0]    r_sel, w_sel_next;
  logic [SLOT_W-1:0]   r_slot, w_slot_next;
  logic                r_done, w_done_next;
  logic                r_err, w_err_next;
  logic                r_busy;

  logic                w_emit_clear;
  logic                w_advance;

  // Ready only once the first clock after reset release has been seen.
  assign req_ready = (r_state == StIdle) && r_init_done;

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    w_state_next      = r_state;
    w_clr_sel_next    = r_clr_sel;
    w_clr_slot_next   = r_clr_slot;
    w_clearing_next   = r_clearing;
    w_gap_cnt_next    = r_gap_cnt;
    w_conf_valid_next = 1'b0;
    w_link_valid_next = 1'b0;
    w_data_next       = '0;
    w_sel_next        = '0;
    w_slot_next       = '0;
    w_done_next       = 1'b0;
    w_err_next        = 1'b0;
    w_emit_clear      = 1'b0;
    w_advance         = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (req_valid && req_ready) begin
          unique case (req_op)
            2'b00: begin
              if (req_data > UNASSIGNED) begin
                w_err_next = 1'b1;
              end else begin
                w_state_next      = StWrite;
                w_conf_valid_next = 1'b1;
                w_data_next       = req_data;
                w_sel_next        = req_sel;
                w_slot_next       = req_slot;
                w_done_next       = 1'b1;
              end
            end
            2'b01: w_emit_clear = 1'b1;
            2'b10: begin
              w_state_next      = StCommit;
              w_link_valid_next = 1'b1;
              w_data_next       = req_data;
              w_done_next       = 1'b1;
            end
            default: w_err_next = 1'b1;
          endcase
        end
      end
      StWrite, StClear, StCommit: begin
        if (GAP_EN) begin
          w_state_next   = StGap;
          w_gap_cnt_next = '0;
        end else begin
          w_advance = 1'b1;
        end
      end
      StGap: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_advance = 1'b1;
        end else begin
          w_gap_cnt_next = r_gap_cnt + 4'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase

    // After a pulse (and its gap) either continue a clear sweep or go idle.
    if (w_advance) begin
      if (r_clearing) begin
        w_emit_clear = 1'b1;
      end else begin
        w_state_next = StIdle;
      end
    end

    // One clear pulse from the sweep counters; counters wrap after the last entry.
    if (w_emit_clear) begin
      w_state_next      = StClear;
      w_conf_valid_next = 1'b1;
      w_data_next       = UNASSIGNED;
      w_sel_next        = r_clr_sel;
      w_slot_next       = r_clr_slot;
      if (r_clr_sel == SEL_LAST && r_clr_slot == SLOT_LAST) begin
        w_done_next     = 1'b1;
        w_clearing_next = 1'b0;
        w_clr_sel_next  = '0;
        w_clr_slot_next = '0;
      end else begin
        w_clearing_next = 1'b1;
        if (r_clr_slot == SLOT_LAST) begin
          w_clr_slot_next = '0;
          w_clr_sel_next  = r_clr_sel + 1'b1;
        end else begin
          w_clr_slot_next = r_clr_slot + 1'b1;
        end
      end
    end
  end

  // State, sweep counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_clr_sel    <= '0;
      r_clr_slot   <= '0;
      r_clearing   <= 1'b0;
      r_gap_cnt    <= '0;
      r_init_done  <= 1'b0;
      r_conf_valid <= 1'b0;
      r_link_valid <= 1'b0;
      r_data       <= '0;
      r_sel        <= '0;
      r_slot       <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_clr_sel    <= w_clr_sel_next;
      r_clr_slot   <= w_clr_slot_next;
      r_clearing   <= w_clearing_next;
      r_gap_cnt    <= w_gap_cnt_next;
      r_init_done  <= 1'b1;
      r_conf_valid <= w_conf_valid_next;
      r_link_valid <= w_link_valid_next;
      r_data       <= w_data_next;
      r_sel        <= w_sel_next;
      r_slot       <= w_slot_next;
      r_done       <= w_done_next;
      r_err        <= w_err_next;
      r_busy       <= (w_state_next != StIdle);
    end
  end

  assign lut_conf_valid = r_conf_valid;
  assign link_en_valid  = r_link_valid;
  assign lut_conf_data  = r_data;
  assign lut_conf_sel   = r_sel;
  assign lut_conf_slot  = r_slot;
  assign done           = r_done;
  assign err            = r_err;
  assign busy           = r_busy;

`ifdef TDM_LUT_CONF_SHADOW_EN
  logic [DATA_W-1:0] r_shadow [TDM_CHANNELS][TDM_LUT_SIZE];
  logic [DATA_W-1:0] r_link_en_mask;

  // Shadow copy of what has been pushed to the LUTs and the last link mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TDM_CHANNELS; i++) begin
        for (int j = 0; j < TDM_LUT_SIZE; j++) begin
          r_shadow[i][j] <= UNASSIGNED;
        end
      end
      r_link_en_mask <= '0;
    end else begin
      if (r_conf_valid) begin
        r_shadow[r_sel][r_slot] <= r_data;
      end
      if (r_link_valid) begin
        r_link_en_mask <= r_data;
      end
    end
  end

  assign rd_data      = r_shadow[rd_sel][rd_slot];
  assign link_en_mask = r_link_en_mask;
`endif

endmodule

// File: doc/tdm_lut_conf_sequencer.md
TDM_LUT_CONF_SEQUENCER -- requirements
Module: tdm_lut_conf_sequencer

Interface
REQ-001 SHALL have parameter TDM_LUT_SIZE, default 4: number of TDM slots per LUT.
REQ-002 SHALL have parameter TDM_CHANNELS, default 4: number of LUT selects; data value TDM_CHANNELS means "slot unassigned".
REQ-003 SHALL have parameter CONF_GAP, default 1, legal range 0..15: idle cycles enforced after every output pulse.
REQ-004 SHALL have ports: clk, in, 1, sole clock; rst_n, in, 1, asynchronous active-low reset.
REQ-005 SHALL have ports: req_valid, in, 1; req_ready, out, 1; req_op, in, 2 (00 write, 01 clear, 10 commit, 11 illegal).
REQ-006 SHALL have ports: req_sel, in, $clog2(TDM_CHANNELS); req_slot, in, $clog2(TDM_LUT_SIZE); req_data, in, $clog2(TDM_CHANNELS+1) (LUT value or link-enable mask).
REQ-007 SHALL have ports: lut_conf_data, out, $clog2(TDM_CHANNELS+1); lut_conf_sel, out, $clog2(TDM_CHANNELS); lut_conf_slot, out, $clog2(TDM_LUT_SIZE); lut_conf_valid, out, 1; link_en_valid, out, 1.
REQ-008 SHALL have ports: busy, out, 1, FSM not in IDLE; done, out, 1, operation-complete pulse; err, out, 1, rejected-request pulse.

Function
REQ-009 FSM states SHALL be IDLE, WRITE, CLEAR, COMMIT and GAP; req_ready SHALL be 1 only in IDLE.
REQ-010 A request SHALL be accepted on req_valid & req_ready; all fields SHALL be registered at acceptance.
REQ-011 Write accepted at cycle t: lut_conf_valid=1 at t+1 for exactly one cycle, carrying the registered sel/slot/data, with done=1 in the same cycle.
REQ-012 Clear SHALL emit TDM_CHANNELS*TDM_LUT_SIZE lut_conf_valid pulses, each with data=TDM_CHANNELS; slot is the inner counter, sel the outer, both starting at 0.
REQ-013 Clear SHALL insert a GAP after every pulse; done=1 only with the final pulse (sel=TDM_CHANNELS-1, slot=TDM_LUT_SIZE-1); counters SHALL wrap to 0 afterwards.
REQ-014 Commit SHALL emit link_en_valid=1 for one cycle at t+1 with lut_conf_data=req_data and done=1.
REQ-015 After each pulse the FSM SHALL stay in GAP for CONF_GAP cycles, then go to the next pulse or IDLE; with CONF_GAP=0, GAP SHALL be skipped.
REQ-016 Write with req_data>TDM_CHANNELS, or op=11, SHALL be consumed without any output pulse: err=1 at t+1 and FSM remains in IDLE.
REQ-017 lut_conf_data/sel/slot SHALL be 0 whenever both lut_conf_valid and link_en_valid are 0.
REQ-018 lut_conf_valid and link_en_valid SHALL never be high in the same cycle.
REQ-019 busy SHALL be 1 from t+1 until the cycle the FSM re-enters IDLE.
REQ-020 Write latency: for a write accepted at t, req_ready SHALL return at t+2+CONF_GAP.
REQ-021 All outputs SHALL be registered (no combinational path from req_* to outputs), except req_ready, which is decoded from state.

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, counters to 0, all pulses/data outputs to 0, busy=0 and req_ready=0.
REQ-023 req_ready SHALL be 1 from the first clk edge after rst_n deasserts.
REQ-024 Reset asserted mid-clear SHALL abort the sweep with no further pulses; a later clear SHALL restart at sel=0, slot=0.

Configuration
REQ-025 Macro TDM_LUT_CONF_SHADOW_EN SHALL control the shadow-readback feature.
REQ-026 With TDM_LUT_CONF_SHADOW_EN defined, the block SHALL add ports rd_sel (in), rd_slot (in), rd_data (out, combinational) and link_en_mask (out).
REQ-027 With the macro defined, a shadow table SHALL be updated on every lut_conf_valid pulse and link_en_mask on every link_en_valid pulse.
REQ-028 With the macro defined, the shadow table SHALL reset to TDM_CHANNELS in every entry and link_en_mask SHALL reset to 0.
REQ-029 Without the macro, the shadow ports and storage SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Write sel=2, slot=1, data=3 accepted at t, CONF_GAP=1 -> lut_conf_valid at t+1 with 2/1/3, done at t+1, req_ready at t+3.
REQ-031 Clear, defaults -> 16 pulses of data=4 in order (0,0),(0,1)…(3,3), each 2 cycles apart; done only on pulse 16.
REQ-032 Commit with data=3'b101 -> single link_en_valid with lut_conf_data=5, lut_conf_valid stays 0.
REQ-033 Write with data=5 (>4), or op=11 -> err pulse at t+1, no output pulses, req_ready stays 1.
REQ-034 rst_n low after pulse 7 of a clear -> outputs 0 immediately; next clear starts at (0,0); with shadow enabled, rd_data=4 for all entries after reset.
